// File: rtl/count_up.sv
// ----------------------------------------------------------------------------
// count_up: up-counting MM:SS stopwatch in BCD.
//
// Counts elapsed time from 00:00, one second per rising clk_out edge while
// running. It supports start/pause, a lap freeze of the displayed value and
// clear. It drives the same four BCD digit outputs as the countdown timer, so
// either block can sit behind the display mux.
//
// Handshake: start_stop, lap and clear are single-cycle pulses, synchronous
// to clk_out and already debounced. There is no valid/ready pairing. A pulse
// high at a rising edge is consumed on that edge.
//
// Ports:
//   clk_out     in   count clock (one edge = one second in RUN)
//   reset_n     in   asynchronous active-low reset
//   start_stop  in   toggles run/pause (starts from IDLE)
//   lap         in   toggles lap freeze of the display (RUN/PAUSE only)
//   clear       in   back to 00:00 and IDLE from any state
//   c0..c3      out  minutes tens, minutes ones, seconds tens, seconds ones
//   running     out  high in RUN
//   done        out  high in DONE (saturated at MAX_MIN:59, WRAP=0)
//   lap_active  out  high while the display shows the hold register
//   state_dbg   out  current FSM state (0 IDLE, 1 RUN, 2 PAUSE, 3 DONE)
// ----------------------------------------------------------------------------
module count_up #(
    parameter int MAX_MIN = 59,
    parameter bit WRAP    = 1'b0
) (
    input  logic       clk_out,
    input  logic       reset_n,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] c0,
    output logic [3:0] c1,
    output logic [3:0] c2,
    output logic [3:0] c3,
    output logic       running,
    output logic       done,
    output logic       lap_active,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  TERM_M10 = 4'(MAX_MIN / 10);
    localparam logic [3:0]  TERM_M1  = 4'(MAX_MIN % 10);
    localparam logic [15:0] TERM     = {TERM_M10, TERM_M1, 4'd5, 4'd9};

    // Digit packing: [15:12] min tens, [11:8] min ones, [7:4] sec tens, [3:0] sec ones.
    state_t      state_q, state_d;
    logic [15:0] live_q, live_d;
    logic [15:0] hold_q, hold_d;
    logic        lap_q, lap_d;

    logic [15:0] live_inc;
    logic        at_term;

    assign at_term = (live_q == TERM);

    // BCD ripple increment of the live count.
    always_comb begin
        live_inc = live_q;
        if (live_q[3:0] != 4'd9) begin
            live_inc[3:0] = live_q[3:0] + 4'd1;
        end else begin
            live_inc[3:0] = 4'd0;
            if (live_q[7:4] != 4'd5) begin
                live_inc[7:4] = live_q[7:4] + 4'd1;
            end else begin
                live_inc[7:4] = 4'd0;
                if (live_q[11:8] != 4'd9) begin
                    live_inc[11:8] = live_q[11:8] + 4'd1;
                end else begin
                    live_inc[11:8] = 4'd0;
                    // Only reachable with MAX_MIN = 99 wrapping; keep it in BCD.
                    live_inc[15:12] = (live_q[15:12] == 4'd9) ? 4'd0 : live_q[15:12] + 4'd1;
                end
            end
        end
    end

    // Next-state logic. Priority: clear > start_stop > lap > increment.
    always_comb begin
        state_d = state_q;
        live_d  = live_q;
        hold_d  = hold_q;
        lap_d   = lap_q;
        if (clear) begin
            state_d = S_IDLE;
            live_d  = 16'h0000;
            hold_d  = 16'h0000;
            lap_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_stop) state_d = S_RUN;
                end
                S_RUN: begin
                    if (start_stop) begin
                        state_d = S_PAUSE;
                    end else if (at_term && !WRAP) begin
                        // Saturate: the count stays at the terminal value and the freeze is released.
                        state_d = S_DONE;
                        lap_d   = 1'b0;
                    end else begin
                        if (lap) begin
                            if (!lap_q) hold_d = live_q;
                            lap_d = !lap_q;
                        end
                        live_d = at_term ? 16'h0000 : live_inc;
                    end
                end
                S_PAUSE: begin
                    if (start_stop) begin
                        state_d = S_RUN;
                    end else if (lap) begin
                        if (!lap_q) hold_d = live_q;
                        lap_d = !lap_q;
                    end
                end
                default: begin
                    // DONE: only clear or reset leaves.
                end
            endcase
        end
    end

    always_ff @(posedge clk_out or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            live_q  <= 16'h0000;
            hold_q  <= 16'h0000;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            live_q  <= live_d;
            hold_q  <= hold_d;
            lap_q   <= lap_d;
        end
    end

    // Display mux straight from registers: no added latency.
    logic [15:0] disp;
    assign disp       = lap_q ? hold_q : live_q;
    assign c0         = disp[15:12];
    assign c1         = disp[11:8];
    assign c2         = disp[7:4];
    assign c3         = disp[3:0];
    assign running    = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign lap_active = lap_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/count_up.md
Name: count_up

Overview:
- Up-counting stopwatch; the counterpart of the countdown timer.
- Counts elapsed MM:SS in BCD on every clk_out edge while running, starting from 00:00.
- Supports start/pause, lap-freeze and clear.
- Drives the same four BCD digit outputs consumed by the seven-segment display path, so the two blocks are interchangeable behind the display mux.

Parameters:
- MAX_MIN, 59, terminal minute value (1..99); the count stops or wraps after MAX_MIN:59.
- WRAP, 0, 0 = saturate at MAX_MIN:59 and enter DONE; 1 = roll over to 00:00 and keep running.

Ports:
- clk_out  input  1  count clock; each rising edge in RUN is one second.
- reset_n  input  1  asynchronous active-low reset.
- start_stop  input  1  single-cycle pulse, synchronous to clk_out, already debounced; toggles run/pause.
- lap  input  1  single-cycle pulse; toggles lap-freeze of the displayed value.
- clear  input  1  single-cycle pulse; returns to 00:00 and IDLE.
- c0  output  4  minutes tens (BCD).
- c1  output  4  minutes ones (BCD).
- c2  output  4  seconds tens (BCD, 0..5).
- c3  output  4  seconds ones (BCD, 0..9).
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- lap_active  output  1  high while the display is frozen.

Behaviour:
- Interface: one clock (clk_out); reset_n is asynchronous, active-low.
- Reset: state=IDLE; live count=00:00; lap hold register=00:00; c0..c3=0; running=0; done=0; lap_active=0.
- Registers: live count (4 BCD digits), hold register (4 BCD digits), 2-bit state {IDLE, RUN, PAUSE, DONE}, lap_active flag.
- Outputs: c0..c3 show the hold register when lap_active=1, otherwise the live count. Output mux is combinational from registers; no extra latency.
- Priority per edge: clear > start_stop > lap > increment.
- clear (any state): live=00:00, hold=00:00, lap_active=0, state=IDLE.
- IDLE: start_stop -> RUN. No increment on that edge; first increment on the next edge.
- RUN, no start_stop: increment live by 1 s each edge.
- RUN + start_stop -> PAUSE. No increment on that edge.
- PAUSE: count held; start_stop -> RUN, no increment on that edge.
- DONE: start_stop and lap ignored; only clear or reset leaves DONE.
- Increment arithmetic:
  - c3 wraps 9->0 and carries to c2.
  - c2 wraps 5->0 and carries to c1.
  - c1 wraps 9->0 and carries to c0.
  - Digits never leave BCD range.
- Terminal value: live == {MAX_MIN/10, MAX_MIN%10, 5, 9}.
  - Reached with WRAP=0: on the next RUN edge, state=DONE, count stays at terminal, lap_active forced 0.
  - Reached with WRAP=1: the next increment yields 00:00 and state stays RUN.
- Lap (RUN or PAUSE only):
  - lap with lap_active=0: hold <= live value present before this edge; lap_active=1.
  - lap with lap_active=1: lap_active=0 and the display returns to live.
  - The live count keeps incrementing in RUN regardless of lap.
  - lap in IDLE is ignored.
- Simultaneous start_stop and lap: start_stop applies and lap is dropped that edge.
- Reset mid-operation: asynchronous return to reset values regardless of state or lap.

Test Plan:
- Reset, start_stop pulse, then 75 edges -> c0..c3 = 0,1,1,5 (01:15); running=1.
- Run to 00:09 -> next edge 00:10; from 00:59 -> 01:00; from 09:59 -> 10:00.
- MAX_MIN=1, WRAP=0, run to 01:59, one more edge -> done=1, running=0, display 01:59; start_stop ignored; clear -> 00:00, IDLE.
- MAX_MIN=1, WRAP=1, at 01:59 one edge -> 00:00, running=1.
- At 00:20, lap pulse, then 10 edges -> display 00:20, lap_active=1; lap pulse -> display 00:31 (00:30 plus the increment on the lap edge).
- At 00:05 in RUN, assert start_stop and clear on the same edge -> 00:00, IDLE; with reset_n low mid-RUN -> all outputs 0 immediately.
